// File: rtl/lutram_fifo.sv
// lutram_fifo: 64-entry first-word-fall-through FIFO built from WIDTH
// single-bit ram64x1d LUT RAMs (synchronous write port A, asynchronous
// read port B). Occupancy is tracked by an explicit counter, so full and
// empty never depend on pointer comparison.
// Optional sticky overflow/underflow flags: define LUTRAM_FIFO_ERRFLAGS_EN.

// 64x1 dual-port LUT RAM: synchronous write on port A, async reads on both ports.
module ram64x1d (
    input  logic       a_clk,
    input  logic [5:0] a_addr,
    input  logic       a_wren,
    input  logic       a_wrdata,
    output logic       a_rddata,
    input  logic [5:0] b_addr,
    output logic       b_rddata
);
    logic [63:0] mem;

    // Port A write; contents are never cleared
    always_ff @(posedge a_clk) begin
        if (a_wren) begin
            mem[a_addr] <= a_wrdata;
        end
    end

    assign a_rddata = mem[a_addr];
    assign b_rddata = mem[b_addr];
endmodule

module lutram_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AFULL = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en,
    output logic             empty,
    output logic [6:0]       count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    logic [5:0]       wr_ptr;
    logic [5:0]       rd_ptr;
    logic [6:0]       count_next;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] a_rddata_unused;

    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    // One LUT RAM per data bit; port B gives zero-latency head data
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ram64x1d u_ram (
            .a_clk    (clk),
            .a_addr   (wr_ptr),
            .a_wren   (push),
            .a_wrdata (wr_data[i]),
            .a_rddata (a_rddata_unused[i]),
            .b_addr   (rd_ptr),
            .b_rddata (rd_data[i])
        );
    end

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 7'd1;
        end else if (!push && pop) begin
            count_next = count - 7'd1;
        end
    end

    // Pointers, count and registered status flags derived from next count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 6'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 6'd1;
            end
            count       <= count_next;
            empty       <= (count_next == 7'd0);
            full        <= (count_next == 7'd64);
            almost_full <= (count_next >= 7'(AFULL));
        end
    end

`ifdef LUTRAM_FIFO_ERRFLAGS_EN
    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule

// File: tb/tb_lutram_fifo.sv
// Testbench for lutram_fifo: vector table for the basic push/pop cases,
// hand-written sequences for fill/overflow, wrap, simultaneous events and
// mid-stream reset, with a data scoreboard queue.
module tb_lutram_fifo;
`ifdef LUTRAM_FIFO_ERRFLAGS_EN
    localparam bit ERRF = 1'b1;
`else
    localparam bit ERRF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       empty;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    lutram_fifo #(.WIDTH(8), .AFULL(48)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .rd_data     (rd_data),
        .rd_en       (rd_en),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference state
    logic [7:0] sb[$];
    int         m_count = 0;
    bit         m_ovf = 0;
    bit         m_udf = 0;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] wd;
        int         cnt;
        logic       emp;
        logic       chk_head;
        logic [7:0] head;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".empty"}, int'(empty), int'(m_count == 0));
        chk({tag, ".full"}, int'(full), int'(m_count == 64));
        chk({tag, ".almost_full"}, int'(almost_full), int'(m_count >= 48));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_udf));
        if (m_count > 0) begin
            chk({tag, ".rd_data"}, int'(rd_data), int'(sb[0]));
        end
    endtask

    // One clock: drive, update the reference, clock, then check at #1 after the edge
    task automatic step(input logic we, input logic [7:0] wd, input logic re,
                        input logic ec, input string tag);
        bit m_push;
        bit m_pop;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        m_push  = we && (m_count < 64);
        m_pop   = re && (m_count > 0);
        if (m_pop) begin
            chk({tag, ".pop_head"}, int'(rd_data), int'(sb[0]));
            void'(sb.pop_front());
        end
        if (m_push) begin
            sb.push_back(wd);
        end
        if (ERRF) begin
            if (we && m_count == 64) m_ovf = 1;
            else if (ec) m_ovf = 0;
            if (re && m_count == 0) m_udf = 1;
            else if (ec) m_udf = 0;
        end
        m_count = m_count + int'(m_push) - int'(m_pop);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        chk_status(tag);
    endtask

    task automatic apply_reset(input logic we);
        reset = 1'b1;
        wr_en = we;
        wr_data = 8'h5A;
        rd_en = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        m_count = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    initial begin
        vecs[0] = '{we: 1, re: 0, wd: 8'h11, cnt: 1, emp: 0, chk_head: 1, head: 8'h11};
        vecs[1] = '{we: 0, re: 1, wd: 8'h00, cnt: 0, emp: 1, chk_head: 0, head: 8'h00};
        vecs[2] = '{we: 0, re: 1, wd: 8'h00, cnt: 0, emp: 1, chk_head: 0, head: 8'h00};
        vecs[3] = '{we: 1, re: 1, wd: 8'h22, cnt: 1, emp: 0, chk_head: 1, head: 8'h22};
        vecs[4] = '{we: 1, re: 0, wd: 8'h33, cnt: 2, emp: 0, chk_head: 1, head: 8'h22};
        vecs[5] = '{we: 1, re: 1, wd: 8'h44, cnt: 2, emp: 0, chk_head: 1, head: 8'h33};
        vecs[6] = '{we: 0, re: 1, wd: 8'h00, cnt: 1, emp: 0, chk_head: 1, head: 8'h44};
        vecs[7] = '{we: 0, re: 1, wd: 8'h00, cnt: 0, emp: 1, chk_head: 0, head: 8'h00};

        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        apply_reset(1'b0);

        // Reset state, then idle
        chk("rst.count", int'(count), 0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full", int'(full), 0);
        chk("rst.almost_full", int'(almost_full), 0);
        chk("rst.overflow", int'(overflow), 0);
        chk("rst.underflow", int'(underflow), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Table: single push/pop, pop on empty, simultaneous on empty
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].re, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d.tbl_empty", i), int'(empty), int'(vecs[i].emp));
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d.tbl_head", i), int'(rd_data), int'(vecs[i].head));
            end
        end
        if (ERRF) chk("udf.set", int'(underflow), 1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "udf_hold");
        if (ERRF) chk("udf.held", int'(underflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "errclr");
        chk("errclr.underflow", int'(underflow), 0);

        // Fill 0x00..0x3F, almost_full edge at 48
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            if (i == 46) chk("fill.af_before48", int'(almost_full), 0);
            if (i == 47) chk("fill.af_at48", int'(almost_full), 1);
        end
        chk("fill.full", int'(full), 1);
        chk("fill.count", int'(count), 64);
        step(1'b1, 8'hAA, 1'b0, 1'b0, "extra_push");
        chk("extra_push.count", int'(count), 64);
        if (ERRF) chk("ovf.set", int'(overflow), 1);
        // Simultaneous at full: pop accepted, 0xBB dropped
        step(1'b1, 8'hBB, 1'b1, 1'b0, "full_wr_rd");
        chk("full_wr_rd.count", int'(count), 63);
        chk("full_wr_rd.head", int'(rd_data), 8'h01);
        for (int i = 1; i < 64; i++) begin
            chk("drain.order", int'(rd_data), i);
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain.empty", int'(empty), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "errclr2");
        chk("errclr2.overflow", int'(overflow), 0);

        // Pointer wrap at steady occupancy of 5
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "wrap_pre");
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0, "wrap");
            if (count != 7'd5) chk("wrap.count5", int'(count), 5);
        end
        chk("wrap.count_end", int'(count), 5);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

        // Error in the same cycle as err_clr: the set wins
        step(1'b0, 8'h00, 1'b1, 1'b1, "set_vs_clr");
        if (ERRF) chk("set_vs_clr.underflow", int'(underflow), 1);

        // Mid-stream reset with a push pending discards everything
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "pre_rst");
        apply_reset(1'b1);
        chk("midrst.count", int'(count), 0);
        chk("midrst.empty", int'(empty), 1);
        chk("midrst.almost_full", int'(almost_full), 0);
        chk("midrst.overflow", int'(overflow), 0);
        chk("midrst.underflow", int'(underflow), 0);
        step(1'b1, 8'h5C, 1'b0, 1'b0, "post_rst");
        chk("post_rst.head", int'(rd_data), 8'h5C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
